// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line port and memory-side burst port of the cacheline adaptor
interface cacheline_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic         error_o;
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o, error_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: 256-bit cache line <-> 4x64-bit memory burst adaptor; CACHELINE_ADAPTOR_TIMEOUT_EN adds a resp_i watchdog
module cacheline_adaptor #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst,
  cacheline_adaptor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0]   state_q, state_d, k_q, k_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] buf_q, buf_d, line_q, line_d;
  logic         err_q, err_d;
  logic         busy, beat, last, tmo;
  assign busy = state_q == READ || state_q == WRITE;
  assign beat = busy && bus.resp_i;
  assign last = beat && k_q == 2'd3;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  assign tmo  = busy && !bus.resp_i && wd_q == WW'(TIMEOUT_CYCLES - 1);
  assign wd_d = busy && !bus.resp_i && !tmo ? wd_q + 1'b1 : '0;
  always_ff @(posedge clk) wd_q <= rst ? '0 : wd_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    k_d     = beat ? k_q + 2'd1 : k_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    line_d  = line_q;
    err_d   = (!busy && bus.resp_i) || tmo;
    if (state_q == IDLE && (bus.read_i || bus.write_i)) begin
      state_d = bus.write_i ? WRITE : READ;
      addr_d  = {bus.address_i[31:5], 5'b0};
      buf_d   = bus.write_i ? bus.line_i : buf_q;
      k_d     = '0;
      err_d   = err_d || (bus.read_i && bus.write_i);
    end
    if (state_q == READ && beat) buf_d[{k_q, 6'b0} +: 64] = bus.burst_i;
    if (state_q == READ && last) line_d = {bus.burst_i, buf_q[191:0]};
    if (last) state_d = DONE;
    if (tmo || state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end
  assign bus.read_o    = state_q == READ;
  assign bus.write_o   = state_q == WRITE;
  assign bus.resp_o    = state_q == DONE;
  assign bus.error_o   = err_q;
  assign bus.address_o = addr_q;
  assign bus.line_o    = line_q;
  assign bus.burst_o   = state_q == WRITE ? buf_q[{k_q, 6'b0} +: 64] : '0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;
  localparam logic [255:0] L_READ  = {64'h0D, 64'h0C, 64'h0B, 64'h0A};
  localparam logic [255:0] L_FRESH = {64'h4, 64'h3, 64'h2, 64'h1};
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  cacheline_adaptor_if bus();
  cacheline_adaptor #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.line_i = '0;
    bus.address_i = '0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.burst_i = '0;
    bus.resp_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    total++; if ({bus.read_o, bus.write_o, bus.resp_o, bus.error_o} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.read_o, bus.write_o, bus.resp_o, bus.error_o}); end
    total++; if (bus.address_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.address_o); end
    total++; if (bus.burst_o !== 64'h0) begin bad++; $display("FAIL reset_burst: got %h want 0", bus.burst_o); end
    total++; if (bus.line_o !== 256'h0) begin bad++; $display("FAIL reset_line: got %h want 0", bus.line_o); end
  endtask
  task automatic test_read();
    bus.address_i = 32'h1234_5678;
    bus.read_i = 1'b1;
    step();
    total++; if (bus.address_o !== 32'h1234_5660) begin bad++; $display("FAIL read_addr: got %h want 12345660", bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = 64'h0A + 64'(i);
      total++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin bad++; $display("FAIL read_beat%0d: got read_o=%b resp_o=%b want 1 0", i, bus.read_o, bus.resp_o); end
      step();
    end
    bus.resp_i = 1'b0;
    total++; if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0) begin bad++; $display("FAIL read_done: got resp_o=%b read_o=%b want 1 0", bus.resp_o, bus.read_o); end
    total++; if (bus.line_o !== L_READ) begin bad++; $display("FAIL read_line: got %h want %h", bus.line_o, L_READ); end
    bus.read_i = 1'b0;
    step();
    total++; if (bus.resp_o !== 1'b0 || bus.line_o !== L_READ) begin bad++; $display("FAIL read_after: got resp_o=%b line=%h want 0 %h", bus.resp_o, bus.line_o, L_READ); end
  endtask
  task automatic test_write();
    logic [63:0] exp_b [5] = '{64'h11, 64'h22, 64'h22, 64'h33, 64'h44};
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.line_i = {64'h44, 64'h33, 64'h22, 64'h11};
    bus.address_i = 32'h0000_1040;
    bus.write_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.resp_i = pat[i];
      total++; if (bus.write_o !== 1'b1 || bus.burst_o !== exp_b[i]) begin bad++; $display("FAIL write_beat%0d: got write_o=%b burst=%h want 1 %h", i, bus.write_o, bus.burst_o, exp_b[i]); end
      step();
    end
    bus.resp_i = 1'b0;
    total++; if (bus.write_o !== 1'b0 || bus.resp_o !== 1'b1) begin bad++; $display("FAIL write_done: got write_o=%b resp_o=%b want 0 1", bus.write_o, bus.resp_o); end
    total++; if (bus.line_o !== L_READ) begin bad++; $display("FAIL write_line_kept: got %h want %h", bus.line_o, L_READ); end
    bus.write_i = 1'b0;
    step();
    total++; if (bus.resp_o !== 1'b0 || bus.error_o !== 1'b0) begin bad++; $display("FAIL write_after: got resp_o=%b error_o=%b want 0 0", bus.resp_o, bus.error_o); end
  endtask
  task automatic test_simultaneous();
    logic [63:0] exp_b [4] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
    bus.line_i = {64'hD4, 64'hC3, 64'hB2, 64'hA1};
    bus.address_i = 32'hABCD_EF1F;
    bus.read_i = 1'b1;
    bus.write_i = 1'b1;
    step();
    total++; if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.error_o !== 1'b1) begin bad++; $display("FAIL simul_accept: got write_o=%b read_o=%b error_o=%b want 1 0 1", bus.write_o, bus.read_o, bus.error_o); end
    total++; if (bus.address_o !== 32'hABCD_EF00) begin bad++; $display("FAIL simul_addr: got %h want abcdef00", bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      total++; if (bus.burst_o !== exp_b[i]) begin bad++; $display("FAIL simul_beat%0d: got %h want %h", i, bus.burst_o, exp_b[i]); end
      step();
      total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL simul_err_pulse%0d: got %b want 0", i, bus.error_o); end
    end
    bus.resp_i = 1'b0;
    total++; if (bus.resp_o !== 1'b1 || bus.line_o !== L_READ) begin bad++; $display("FAIL simul_done: got resp_o=%b line=%h want 1 %h", bus.resp_o, bus.line_o, L_READ); end
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    step();
  endtask
  task automatic test_stray_resp();
    bus.resp_i = 1'b1;
    bus.burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.resp_i = 1'b0;
    total++; if (bus.error_o !== 1'b1 || bus.resp_o !== 1'b0) begin bad++; $display("FAIL stray_err: got error_o=%b resp_o=%b want 1 0", bus.error_o, bus.resp_o); end
    total++; if (bus.line_o !== L_READ) begin bad++; $display("FAIL stray_line: got %h want %h", bus.line_o, L_READ); end
    step();
    total++; if (bus.error_o !== 1'b0 || bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin bad++; $display("FAIL stray_after: got error_o=%b read_o=%b write_o=%b want 0 0 0", bus.error_o, bus.read_o, bus.write_o); end
  endtask
  task automatic test_reset_mid_read();
    bus.address_i = 32'h0000_0100;
    bus.read_i = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = 64'hDEAD_0000 + 64'(i);
      step();
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.read_o !== 1'b0 || bus.line_o !== 256'h0 || bus.address_o !== 32'h0) begin bad++; $display("FAIL rstmid_clear: got read_o=%b line=%h addr=%h want 0 0 0", bus.read_o, bus.line_o, bus.address_o); end
    bus.address_i = 32'h0000_0200;
    bus.read_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      bus.burst_i = 64'(i + 1);
      step();
    end
    bus.resp_i = 1'b0;
    total++; if (bus.resp_o !== 1'b1 || bus.line_o !== L_FRESH) begin bad++; $display("FAIL rstmid_fresh: got resp_o=%b line=%h want 1 %h", bus.resp_o, bus.line_o, L_FRESH); end
    bus.read_i = 1'b0;
    step();
  endtask
  task automatic test_timeout();
    bus.address_i = 32'h0000_0300;
    bus.read_i = 1'b1;
    step();
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      step();
      total++; if (bus.read_o !== 1'b1 || bus.error_o !== 1'b0) begin bad++; $display("FAIL tmo_wait%0d: got read_o=%b error_o=%b want 1 0", i, bus.read_o, bus.error_o); end
    end
    bus.read_i = 1'b0;
    step();
    total++; if (bus.error_o !== 1'b1 || bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin bad++; $display("FAIL tmo_fire: got error_o=%b read_o=%b resp_o=%b want 1 0 0", bus.error_o, bus.read_o, bus.resp_o); end
    step();
    total++; if (bus.error_o !== 1'b0 || bus.read_o !== 1'b0) begin bad++; $display("FAIL tmo_after: got error_o=%b read_o=%b want 0 0", bus.error_o, bus.read_o); end
`else
    for (int i = 0; i < 120; i++) step();
    total++; if (bus.read_o !== 1'b1 || bus.error_o !== 1'b0) begin bad++; $display("FAIL notmo_wait: got read_o=%b error_o=%b want 1 0", bus.read_o, bus.error_o); end
    bus.read_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.read_o !== 1'b0) begin bad++; $display("FAIL notmo_reset: got read_o=%b want 0", bus.read_o); end
`endif
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_stray_resp();
    test_reset_mid_read();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
